timer_multi: RTL and testbench
==============================

# timer_multi

Parametrised multi-channel timer/PWM peripheral on the 16-bit CPU data bus, successor to the single-channel timer. Each channel has its own prescaler, counter, reload (TOP) and duty compare, runs in periodic or one-shot mode, and drives a PWM output. A shared write-1-to-clear status register collects per-channel match flags. A single maskable interrupt line goes to the interrupt controller.

## Interface
- BASE_ADDR, 16'h0440, first bus address of the block
- N_CH, 4, channel count, 1..8
- WIDTH, 16, counter/prescaler/compare width, 1..16; bus bits above WIDTH are ignored on write and read as 0
- i_clk  in  1  system clock; all logic on rising edge
- i_rst_n  in  1  reset; asynchronous, active-low
- i_we  in  1  write strobe, qualifies i_addr/i_data in the same cycle
- i_addr  in  16  bus address
- i_data  in  16  write data
- o_data  out  16  registered read data
- o_pwm  out  N_CH  per-channel PWM, registered
- o_irq  out  1  OR of (flag & irq_en) over channels, registered

## Operation
- Channel c registers at BASE_ADDR + 8*c + offset:
  - offset 0 CTRL: bit0 en, bit1 oneshot, bit2 pwm_en, bit3 irq_en
  - offset 1 PRESC
  - offset 2 CNT
  - offset 3 TOP
  - offset 4 DUTY
  - offsets 5..7 read 0, writes ignored
- STATUS at BASE_ADDR + 8*N_CH: bit c = match flag of channel c.
  - Write 1 clears that bit; write 0 leaves it unchanged.
  - Bits >= N_CH read 0.
- Any other address reads 0. Writes to unmapped addresses have no effect.
- Read: when i_we=0, o_data is loaded with the addressed register at the clock edge. Every edge with i_we=0 updates o_data. When i_we=1, o_data holds its value.
- Per-channel prescaler: internal counter div.
  - When en=1 and div==PRESC: tick, div<=0. Otherwise div<=div+1.
  - PRESC=0 ticks every cycle.
- On tick:
  - If CNT==TOP: CNT<=0, flag<=1; if oneshot=1, en<=0.
  - Otherwise CNT<=CNT+1.
  - TOP=0 gives a flag on every tick.
- Counter arithmetic is modulo 2^WIDTH. If CNT>TOP (set by a CNT write), CNT counts up, wraps through 0, and matches TOP on the next pass.
- en=0: div, CNT and the flag freeze. The registers remain readable and writable.
- PWM: o_pwm[c] <= en & pwm_en & (CNT < DUTY), evaluated on register values before the edge.
  - DUTY=0 gives constant low.
  - DUTY>TOP gives constant high while enabled.
- o_irq <= |(flag & irq_en).
- Collision rules:
  - A CNT write in the same cycle as a tick: the write wins. div still advances or reloads normally.
  - A CTRL write that sets en (0->1) also clears div to 0. A PRESC write clears div to 0.
  - A STATUS write-1 clear in the same cycle as a new match: the flag stays 1 (set wins).
  - A CTRL write with en=1 in the same cycle as a one-shot expiry: the write wins, and the channel stays enabled.

## Timing
- Reset values: o_data=0, o_pwm=0, o_irq=0. All CTRL, PRESC, CNT, TOP, DUTY, div and flags are 0.
- Reset is asynchronous. Asserting i_rst_n mid-count clears all state immediately, without waiting for a clock edge. Release is synchronous to the next edge.
- Read latency is 1 cycle: address presented before edge E, data valid after E.
- Write takes effect at the edge where i_we=1.
- With en set at edge E0 and PRESC=P:
  - The first tick is at edge E0+P+1, so CNT=1 after that edge.
  - Ticks then repeat every P+1 edges.
- Periodic period is (P+1)*(TOP+1) cycles.
- A flag set at edge Em raises o_irq after edge Em+1. o_irq falls one edge after the clear.
- o_pwm lags the CNT change by 1 cycle.

## Test plan
- Reset: drive registers to nonzero values, then pulse i_rst_n low with no clock edge -> o_data, o_pwm, o_irq read 0 immediately. All registers read 0 after release.
- Channel 0, PRESC=1, TOP=3, periodic, irq_en -> STATUS bit0 sets every 8 cycles. o_irq rises 1 cycle after each flag. Write 16'h0001 to STATUS -> bit0 and o_irq clear.
- Channel 1, one-shot, PRESC=0, TOP=5 -> flag sets 6 cycles after enable. CTRL.en reads 0 afterwards. CNT reads 0 and stays 0.
- Channel 2 PWM, PRESC=0, TOP=9, DUTY=3 -> o_pwm[2] high 3 of every 10 cycles. DUTY=0 -> constant low. DUTY=12 -> constant high.
- Collisions:
  - CNT write of 7 on a tick edge -> CNT reads 7.
  - STATUS clear on a match edge -> flag remains 1.
  - Channels 0 and 3 matching on the same edge -> both status bits set and o_irq asserted once.
- Bus decode with N_CH=2, WIDTH=8:
  - Write 16'hFFFF to TOP -> reads 16'h00FF.
  - Read offset 5 and address BASE_ADDR+17 -> 0.
  - Write STATUS bit 5 -> no effect.

Source files
------------

// File: rtl/timer_multi.sv
// Multi-channel timer/PWM peripheral on the 16-bit CPU bus.
// Per-channel prescaler, counter, TOP reload, duty compare; shared W1C match status and one IRQ.
module timer_multi #(
   parameter logic [15:0] BASE_ADDR = 16'h0440,
   parameter int          N_CH      = 4,
   parameter int          WIDTH     = 16
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_we,
   input  logic [15:0]     i_addr,
   input  logic [15:0]     i_data,
   output logic [15:0]     o_data,
   output logic [N_CH-1:0] o_pwm,
   output logic            o_irq
);
   localparam logic [15:0] STATUS_OFF = 16'(8 * N_CH);

   // ctrl bits: [0] en, [1] oneshot, [2] pwm_en, [3] irq_en
   logic [3:0]       ctrl_q  [N_CH];
   logic [3:0]       ctrl_d  [N_CH];
   logic [WIDTH-1:0] presc_q [N_CH];
   logic [WIDTH-1:0] presc_d [N_CH];
   logic [WIDTH-1:0] cnt_q   [N_CH];
   logic [WIDTH-1:0] cnt_d   [N_CH];
   logic [WIDTH-1:0] top_q   [N_CH];
   logic [WIDTH-1:0] top_d   [N_CH];
   logic [WIDTH-1:0] duty_q  [N_CH];
   logic [WIDTH-1:0] duty_d  [N_CH];
   logic [WIDTH-1:0] div_q   [N_CH];
   logic [WIDTH-1:0] div_d   [N_CH];
   logic [N_CH-1:0]  flag_q, flag_d;
   logic [N_CH-1:0]  pwm_q, pwm_d;
   logic             irq_q, irq_d;
   logic [15:0]      data_q, data_d;

   logic [15:0]      off;
   logic [2:0]       ch;
   logic [2:0]       rg;
   logic             ch_hit;
   logic             st_hit;
   logic [15:0]      rd_val;
   logic [N_CH-1:0]  flag_set;
   logic [N_CH-1:0]  flag_clr;
   logic [N_CH-1:0]  irq_src;

   // Addresses below BASE_ADDR wrap to large offsets and fall outside the map.
   assign off    = i_addr - BASE_ADDR;
   assign ch     = off[5:3];
   assign rg     = off[2:0];
   assign ch_hit = (off < STATUS_OFF);
   assign st_hit = (off == STATUS_OFF);

   always_comb begin
      rd_val = '0;
      if (ch_hit) begin
         for (int c = 0; c < N_CH; c++) begin
            if (ch == 3'(c)) begin
               case (rg)
                  3'd0:    rd_val[3:0]       = ctrl_q[c];
                  3'd1:    rd_val[WIDTH-1:0] = presc_q[c];
                  3'd2:    rd_val[WIDTH-1:0] = cnt_q[c];
                  3'd3:    rd_val[WIDTH-1:0] = top_q[c];
                  3'd4:    rd_val[WIDTH-1:0] = duty_q[c];
                  default: rd_val            = '0;
               endcase
            end
         end
      end else if (st_hit) begin
         rd_val[N_CH-1:0] = flag_q;
      end
   end

   always_comb begin
      data_d   = i_we ? data_q : rd_val;
      flag_set = '0;
      flag_clr = (i_we && st_hit) ? i_data[N_CH-1:0] : '0;
      irq_src  = '0;
      pwm_d    = '0;
      for (int c = 0; c < N_CH; c++) begin
         ctrl_d[c]  = ctrl_q[c];
         presc_d[c] = presc_q[c];
         cnt_d[c]   = cnt_q[c];
         top_d[c]   = top_q[c];
         duty_d[c]  = duty_q[c];
         div_d[c]   = div_q[c];
         pwm_d[c]   = ctrl_q[c][0] & ctrl_q[c][2] & (cnt_q[c] < duty_q[c]);
         irq_src[c] = flag_q[c] & ctrl_q[c][3];

         if (ctrl_q[c][0]) begin
            if (div_q[c] == presc_q[c]) begin
               div_d[c] = '0;
               if (cnt_q[c] == top_q[c]) begin
                  cnt_d[c]    = '0;
                  flag_set[c] = 1'b1;
                  if (ctrl_q[c][1]) ctrl_d[c][0] = 1'b0;
               end else begin
                  cnt_d[c] = cnt_q[c] + 1'b1;
               end
            end else begin
               div_d[c] = div_q[c] + 1'b1;
            end
         end

         // Bus writes override the counting results computed above.
         if (i_we && ch_hit && (ch == 3'(c))) begin
            case (rg)
               3'd0: begin
                  ctrl_d[c] = i_data[3:0];
                  if (i_data[0] && !ctrl_q[c][0]) div_d[c] = '0;
               end
               3'd1: begin
                  presc_d[c] = i_data[WIDTH-1:0];
                  div_d[c]   = '0;
               end
               3'd2:    cnt_d[c]  = i_data[WIDTH-1:0];
               3'd3:    top_d[c]  = i_data[WIDTH-1:0];
               3'd4:    duty_d[c] = i_data[WIDTH-1:0];
               default: ;
            endcase
         end
      end
      flag_d = (flag_q & ~flag_clr) | flag_set;
      irq_d  = |irq_src;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int c = 0; c < N_CH; c++) begin
            ctrl_q[c]  <= '0;
            presc_q[c] <= '0;
            cnt_q[c]   <= '0;
            top_q[c]   <= '0;
            duty_q[c]  <= '0;
            div_q[c]   <= '0;
         end
         flag_q <= '0;
         pwm_q  <= '0;
         irq_q  <= 1'b0;
         data_q <= '0;
      end else begin
         for (int c = 0; c < N_CH; c++) begin
            ctrl_q[c]  <= ctrl_d[c];
            presc_q[c] <= presc_d[c];
            cnt_q[c]   <= cnt_d[c];
            top_q[c]   <= top_d[c];
            duty_q[c]  <= duty_d[c];
            div_q[c]   <= div_d[c];
         end
         flag_q <= flag_d;
         pwm_q  <= pwm_d;
         irq_q  <= irq_d;
         data_q <= data_d;
      end
   end

   assign o_data = data_q;
   assign o_pwm  = pwm_q;
   assign o_irq  = irq_q;

endmodule

// File: tb/tb_timer_multi.sv
// Bench for timer_multi: directed scenarios plus a randomized bus run against a behavioural model.
// A second instance with N_CH=2, WIDTH=8 shares the bus for the decode checks.
module tb_timer_multi;
   localparam int N    = 4;
   localparam int BASE = 'h440;
   localparam int STAT = BASE + 8 * N;

   logic        clk;
   logic        rst_n;
   logic        we;
   logic [15:0] addr;
   logic [15:0] wdata;
   logic [15:0] dout;
   logic [N-1:0] pwm;
   logic        irq;
   logic [15:0] d2_dout;
   logic [1:0]  d2_pwm;
   logic        d2_irq;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model state (values after the most recent edge).
   int m_ctrl [N];
   int m_presc[N];
   int m_cnt  [N];
   int m_top  [N];
   int m_duty [N];
   int m_div  [N];
   bit m_flag [N];
   int m_data;
   int m_pwm;
   bit m_irq;

   timer_multi #(.BASE_ADDR(16'h0440), .N_CH(N), .WIDTH(16)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_we(we), .i_addr(addr), .i_data(wdata),
      .o_data(dout), .o_pwm(pwm), .o_irq(irq)
   );

   timer_multi #(.BASE_ADDR(16'h0440), .N_CH(2), .WIDTH(8)) dut2 (
      .i_clk(clk), .i_rst_n(rst_n), .i_we(we), .i_addr(addr), .i_data(wdata),
      .o_data(d2_dout), .o_pwm(d2_pwm), .o_irq(d2_irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   function automatic void model_reset();
      for (int c = 0; c < N; c++) begin
         m_ctrl[c] = 0; m_presc[c] = 0; m_cnt[c] = 0;
         m_top[c] = 0;  m_duty[c] = 0;  m_div[c] = 0; m_flag[c] = 0;
      end
      m_data = 0; m_pwm = 0; m_irq = 0;
   endfunction

   function automatic int model_read(input int a);
      int off = (a - BASE) & 'hFFFF;
      int v = 0;
      if (off < 8 * N) begin
         case (off % 8)
            0: v = m_ctrl[off / 8];
            1: v = m_presc[off / 8];
            2: v = m_cnt[off / 8];
            3: v = m_top[off / 8];
            4: v = m_duty[off / 8];
            default: v = 0;
         endcase
      end else if (off == 8 * N) begin
         for (int c = 0; c < N; c++) if (m_flag[c]) v += (1 << c);
      end
      return v;
   endfunction

   // One clock edge of the peripheral as described by its rules, old state in, new state out.
   function automatic void model_step(input bit w, input int a, input int d);
      int n_ctrl[N], n_presc[N], n_cnt[N], n_top[N], n_duty[N], n_div[N];
      bit matched[N];
      int nd, np, off, ch;
      bit ni, en, os, pe, ie;
      nd = w ? m_data : model_read(a);
      np = 0;
      ni = 0;
      for (int c = 0; c < N; c++) begin
         en = m_ctrl[c][0]; os = m_ctrl[c][1]; pe = m_ctrl[c][2]; ie = m_ctrl[c][3];
         if (en && pe && (m_cnt[c] < m_duty[c])) np += (1 << c);
         if (m_flag[c] && ie) ni = 1;
         n_ctrl[c] = m_ctrl[c]; n_presc[c] = m_presc[c]; n_cnt[c] = m_cnt[c];
         n_top[c] = m_top[c]; n_duty[c] = m_duty[c]; n_div[c] = m_div[c];
         matched[c] = 0;
         if (en) begin
            if (m_div[c] == m_presc[c]) begin
               n_div[c] = 0;
               if (m_cnt[c] == m_top[c]) begin
                  n_cnt[c] = 0;
                  matched[c] = 1;
                  if (os) n_ctrl[c] = m_ctrl[c] & ~1;
               end else begin
                  n_cnt[c] = (m_cnt[c] + 1) % 65536;
               end
            end else begin
               n_div[c] = (m_div[c] + 1) % 65536;
            end
         end
      end
      off = (a - BASE) & 'hFFFF;
      if (w && off < 8 * N) begin
         ch = off / 8;
         case (off % 8)
            0: begin
               if ((d & 1) && !(m_ctrl[ch] & 1)) n_div[ch] = 0;
               n_ctrl[ch] = d & 15;
            end
            1: begin n_presc[ch] = d; n_div[ch] = 0; end
            2: n_cnt[ch] = d;
            3: n_top[ch] = d;
            4: n_duty[ch] = d;
            default: ;
         endcase
      end
      for (int c = 0; c < N; c++) begin
         if (w && off == 8 * N && ((d >> c) & 1)) m_flag[c] = 0;
         if (matched[c]) m_flag[c] = 1;
         m_ctrl[c] = n_ctrl[c]; m_presc[c] = n_presc[c]; m_cnt[c] = n_cnt[c];
         m_top[c] = n_top[c]; m_duty[c] = n_duty[c]; m_div[c] = n_div[c];
      end
      m_data = nd;
      m_pwm = np;
      m_irq = ni;
   endfunction

   task automatic cyc(input bit w, input logic [15:0] a, input logic [15:0] d);
      we = w; addr = a; wdata = d;
      @(posedge clk);
      #1;
      model_step(w, int'(a), int'(d));
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      cyc(1'b1, a, d);
   endtask

   task automatic rd(input logic [15:0] a);
      cyc(1'b0, a, 16'h0);
   endtask

   task automatic do_reset();
      we = 1'b0;
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      do_reset();
      wr(16'h0441, 16'd0);
      wr(16'h0443, 16'd1);
      wr(16'h0444, 16'd2);
      wr(16'h0440, 16'hD);
      for (int k = 0; k < 5; k++) rd(16'h0443);
      n_checks++;
      if (dout !== 16'd1 || pwm !== 4'b0001 || irq !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_preload: data=%h pwm=%b irq=%b, required 0001/0001/1", dout, pwm, irq);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (dout !== 16'h0 || pwm !== 4'b0 || irq !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_async: data=%h pwm=%b irq=%b, required all 0", dout, pwm, irq);
      end
      #1;
      rst_n = 1'b1;
      model_reset();
      for (int o = 0; o < 5; o++) begin
         rd(16'(BASE + o));
         n_checks++;
         if (dout !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_reg_off%0d: got %h, required 0000", o, dout);
         end
      end
      rd(16'(STAT));
      n_checks++;
      if (dout !== 16'h0 || pwm !== 4'b0 || irq !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_status: data=%h pwm=%b irq=%b, required all 0", dout, pwm, irq);
      end
   endtask

   task automatic test_periodic();
      do_reset();
      wr(16'h0441, 16'd1);
      wr(16'h0443, 16'd3);
      wr(16'h0440, 16'h9);
      for (int k = 1; k <= 9; k++) begin
         rd(16'(STAT));
         if (k == 8 || k == 9) begin
            n_checks++;
            if (dout[0] !== (k == 9) || irq !== (k == 9)) begin
               n_fail++;
               $display("FAIL periodic_first_k%0d: status0=%b irq=%b, required %0d", k, dout[0], irq, k == 9);
            end
         end
      end
      wr(16'(STAT), 16'h0001);
      rd(16'(STAT));
      n_checks++;
      if (dout[0] !== 1'b0 || irq !== 1'b0) begin
         n_fail++;
         $display("FAIL periodic_clear: status0=%b irq=%b, required 0/0", dout[0], irq);
      end
      for (int k = 12; k <= 17; k++) begin
         rd(16'(STAT));
         if (k == 16 || k == 17) begin
            n_checks++;
            if (dout[0] !== (k == 17) || irq !== (k == 17)) begin
               n_fail++;
               $display("FAIL periodic_second_k%0d: status0=%b irq=%b, required %0d", k, dout[0], irq, k == 17);
            end
         end
      end
   endtask

   task automatic test_oneshot();
      do_reset();
      wr(16'h044B, 16'd5);
      wr(16'h0448, 16'h3);
      for (int k = 1; k <= 7; k++) begin
         rd(16'(STAT));
         if (k == 6 || k == 7) begin
            n_checks++;
            if (dout !== ((k == 7) ? 16'h0002 : 16'h0000)) begin
               n_fail++;
               $display("FAIL oneshot_flag_k%0d: got %h, required %h", k, dout, (k == 7) ? 16'h2 : 16'h0);
            end
         end
      end
      rd(16'h0448);
      n_checks++;
      if (dout !== 16'h0002) begin
         n_fail++;
         $display("FAIL oneshot_ctrl: got %h, required 0002", dout);
      end
      for (int k = 0; k < 3; k++) begin
         rd(16'h044A);
         n_checks++;
         if (dout !== 16'h0) begin
            n_fail++;
            $display("FAIL oneshot_cnt%0d: got %h, required 0000", k, dout);
         end
      end
   endtask

   task automatic test_pwm();
      int hi;
      do_reset();
      wr(16'h0453, 16'd9);
      wr(16'h0454, 16'd3);
      wr(16'h0450, 16'h5);
      hi = 0;
      for (int k = 0; k < 30; k++) begin rd(16'h0452); hi += int'(pwm[2]); end
      n_checks++;
      if (hi != 9) begin
         n_fail++;
         $display("FAIL pwm_duty3: high %0d of 30 cycles, required 9", hi);
      end
      wr(16'h0454, 16'd0);
      rd(16'h0452);
      hi = 0;
      for (int k = 0; k < 20; k++) begin rd(16'h0452); hi += int'(pwm[2]); end
      n_checks++;
      if (hi != 0) begin
         n_fail++;
         $display("FAIL pwm_duty0: high %0d of 20 cycles, required 0", hi);
      end
      wr(16'h0454, 16'd12);
      rd(16'h0452);
      hi = 0;
      for (int k = 0; k < 20; k++) begin rd(16'h0452); hi += int'(pwm[2]); end
      n_checks++;
      if (hi != 20) begin
         n_fail++;
         $display("FAIL pwm_duty12: high %0d of 20 cycles, required 20", hi);
      end
   endtask

   task automatic test_collisions();
      do_reset();
      wr(16'h0443, 16'd100);
      wr(16'h0440, 16'h1);
      rd(16'h0442);
      rd(16'h0442);
      wr(16'h0442, 16'd7);
      rd(16'h0442);
      n_checks++;
      if (dout !== 16'd7) begin
         n_fail++;
         $display("FAIL coll_cnt_write: got %0d, required 7", dout);
      end
      rd(16'h0442);
      n_checks++;
      if (dout !== 16'd8) begin
         n_fail++;
         $display("FAIL coll_cnt_next: got %0d, required 8", dout);
      end

      do_reset();
      wr(16'h0443, 16'd3);
      wr(16'h0440, 16'h1);
      for (int k = 0; k < 3; k++) rd(16'(STAT));
      wr(16'(STAT), 16'h0001);
      rd(16'(STAT));
      n_checks++;
      if (dout !== 16'h0001) begin
         n_fail++;
         $display("FAIL coll_clear_on_match: got %h, required 0001", dout);
      end
      wr(16'(STAT), 16'h0001);
      rd(16'(STAT));
      n_checks++;
      if (dout !== 16'h0000) begin
         n_fail++;
         $display("FAIL coll_clear_later: got %h, required 0000", dout);
      end

      do_reset();
      wr(16'h0443, 16'd2);
      wr(16'h045B, 16'd2);
      wr(16'h0458, 16'h9);
      wr(16'h0440, 16'h9);
      wr(16'h045A, 16'd1);
      rd(16'(STAT));
      rd(16'(STAT));
      n_checks++;
      if (dout !== 16'h0000 || irq !== 1'b0) begin
         n_fail++;
         $display("FAIL coll_dual_before: status=%h irq=%b, required 0000/0", dout, irq);
      end
      rd(16'(STAT));
      n_checks++;
      if (dout !== 16'h0009 || irq !== 1'b1) begin
         n_fail++;
         $display("FAIL coll_dual_match: status=%h irq=%b, required 0009/1", dout, irq);
      end

      do_reset();
      wr(16'h044B, 16'd2);
      wr(16'h0448, 16'h3);
      rd(16'h0448);
      rd(16'h0448);
      wr(16'h0448, 16'h3);
      rd(16'h0448);
      n_checks++;
      if (dout !== 16'h0003) begin
         n_fail++;
         $display("FAIL coll_oneshot_ctrl: got %h, required 0003", dout);
      end
      rd(16'(STAT));
      rd(16'h044A);
      n_checks++;
      if (dout !== 16'd2) begin
         n_fail++;
         $display("FAIL coll_oneshot_cnt: got %0d, required 2", dout);
      end
   endtask

   task automatic test_decode();
      do_reset();
      wr(16'h0443, 16'hFFFF);
      rd(16'h0443);
      n_checks++;
      if (d2_dout !== 16'h00FF || dout !== 16'hFFFF) begin
         n_fail++;
         $display("FAIL decode_top_mask: narrow=%h wide=%h, required 00FF/FFFF", d2_dout, dout);
      end
      rd(16'h0445);
      n_checks++;
      if (d2_dout !== 16'h0 || dout !== 16'h0) begin
         n_fail++;
         $display("FAIL decode_off5: narrow=%h wide=%h, required 0000", d2_dout, dout);
      end
      rd(16'h0443);
      rd(16'h0451);
      n_checks++;
      if (d2_dout !== 16'h0) begin
         n_fail++;
         $display("FAIL decode_base17: got %h, required 0000", d2_dout);
      end
      rd(16'h0443);
      rd(16'h043F);
      n_checks++;
      if (dout !== 16'h0) begin
         n_fail++;
         $display("FAIL decode_below_base: got %h, required 0000", dout);
      end
      wr(16'h0443, 16'd0);
      wr(16'h0440, 16'h3);
      rd(16'h0450);
      wr(16'h0450, 16'h0020);
      rd(16'h0450);
      n_checks++;
      if (d2_dout !== 16'h0001) begin
         n_fail++;
         $display("FAIL decode_status_bit5: got %h, required 0001", d2_dout);
      end
      wr(16'h0450, 16'h0001);
      rd(16'h0450);
      n_checks++;
      if (d2_dout !== 16'h0000) begin
         n_fail++;
         $display("FAIL decode_status_clear: got %h, required 0000", d2_dout);
      end
   endtask

   task automatic test_random();
      logic [15:0] a, d;
      int sel;
      do_reset();
      for (int k = 0; k < 1500; k++) begin
         sel = $urandom_range(0, 19);
         if (sel < 16)      a = 16'(BASE + 8 * $urandom_range(0, N - 1) + $urandom_range(0, 7));
         else if (sel < 19) a = 16'(STAT);
         else               a = 16'($urandom_range(0, 'hFFFF));
         d = ($urandom_range(0, 15) == 0) ? 16'($urandom_range(0, 'hFFFF)) : 16'($urandom_range(0, 11));
         cyc($urandom_range(0, 2) == 0, a, d);
         n_checks++;
         if (dout !== 16'(m_data)) begin
            n_fail++;
            $display("FAIL rand_data cyc%0d addr=%h: got %h, required %h", k, a, dout, 16'(m_data));
         end
         n_checks++;
         if (pwm !== 4'(m_pwm)) begin
            n_fail++;
            $display("FAIL rand_pwm cyc%0d: got %b, required %b", k, pwm, 4'(m_pwm));
         end
         n_checks++;
         if (irq !== m_irq) begin
            n_fail++;
            $display("FAIL rand_irq cyc%0d: got %b, required %b", k, irq, m_irq);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      we = 1'b0;
      addr = 16'h0;
      wdata = 16'h0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      test_reset();
      test_periodic();
      test_oneshot();
      test_pwm();
      test_collisions();
      test_decode();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
